// File: rtl/ultrasonic_trig_seq_pkg.sv
// Shared types and constants for the ultrasonic trigger sequencer.
// Tick constants assume a 1 MHz clock (1 tick = 1 us).
package ultrasonic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      WAIT  = 2'd2
   } trig_state_e;

   localparam int TRIG_PULSE_US  = 10;
   localparam int TRIG_PERIOD_US = 100000;

   // Channel index width; a single-channel build still gets a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trig_rr_pick.sv
// Round-robin channel picker: next set mask bit above the current index,
// wrapping to the lowest set bit; 'first' selects the lowest set bit directly.
module trig_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [IDX_W-1:0]  cur_idx_i,
   input  logic              first_i,
   output logic [IDX_W-1:0]  nxt_idx_o,
   output logic              wrap_o,
   output logic              none_o
);

   logic [IDX_W-1:0] lo_idx;
   logic [IDX_W-1:0] hi_idx;
   logic             lo_found;
   logic             hi_found;

   // Scanning downwards leaves the lowest qualifying index as the final assignment.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      lo_found = 1'b0;
      hi_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lo_idx   = i[IDX_W-1:0];
            lo_found = 1'b1;
            if (i > int'(cur_idx_i)) begin
               hi_idx   = i[IDX_W-1:0];
               hi_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      none_o = ~lo_found;
      if (first_i || !hi_found) begin
         nxt_idx_o = lo_idx;
         wrap_o    = ~first_i & lo_found;
      end else begin
         nxt_idx_o = hi_idx;
         wrap_o    = 1'b0;
      end
   end

endmodule

// File: rtl/ultrasonic_trig_seq.sv
// Multi-channel ultrasonic trigger sequencer: one channel fires per slot,
// round-robin over a mask sampled at slot boundaries, continuous or single-sweep.
module ultrasonic_trig_seq
   import ultrasonic_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int PULSE_TICKS  = TRIG_PULSE_US,
   parameter int PERIOD_TICKS = TRIG_PERIOD_US,
   parameter int CNT_W        = 20,
   parameter int IDX_W        = idx_w(NUM_CH)
) (
   input  logic              clk_1m,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic [NUM_CH-1:0] trig,
   output logic [IDX_W-1:0]  ch_idx,
   output logic              slot_start,
   output logic              busy,
   output logic              sweep_done
);

   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_TICKS - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_TICKS - 1);

   trig_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [NUM_CH-1:0] trig_q;
   logic [IDX_W-1:0]  ch_idx_q;
   logic              slot_start_q;
   logic              busy_q;
   logic              sweep_done_q;

   logic [IDX_W-1:0]  pick_idx;
   logic              pick_wrap;
   logic              pick_none;
   logic              launch_req;

   trig_rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .mask_i    (ch_mask),
      .cur_idx_i (ch_idx_q),
      .first_i   (state_q == IDLE),
      .nxt_idx_o (pick_idx),
      .wrap_o    (pick_wrap),
      .none_o    (pick_none)
   );

   assign cnt_d      = cnt_q + 1'b1;
   assign launch_req = en & ~pick_none & (~mode | start);

   always_ff @(posedge clk_1m) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         trig_q       <= '0;
         ch_idx_q     <= '0;
         slot_start_q <= 1'b0;
         busy_q       <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         slot_start_q <= 1'b0;
         sweep_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch_req) begin
                  state_q      <= PULSE;
                  cnt_q        <= '0;
                  trig_q       <= NUM_CH'(1) << pick_idx;
                  ch_idx_q     <= pick_idx;
                  slot_start_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            PULSE: begin
               if (!en) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  trig_q  <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_q == PULSE_LAST) begin
                     state_q <= WAIT;
                     trig_q  <= '0;
                  end
               end
            end
            WAIT: begin
               if (!en) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == PERIOD_LAST) begin
                  // Slot boundary: mask and mode are only looked at here.
                  cnt_q <= '0;
                  if (pick_none) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else if (mode && pick_wrap) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     sweep_done_q <= 1'b1;
                  end else begin
                     state_q      <= PULSE;
                     trig_q       <= NUM_CH'(1) << pick_idx;
                     ch_idx_q     <= pick_idx;
                     slot_start_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               trig_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign trig       = trig_q;
   assign ch_idx     = ch_idx_q;
   assign slot_start = slot_start_q;
   assign busy       = busy_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ultrasonic_trig_seq.sv
// Randomised and directed bench for ultrasonic_trig_seq against a slot-timing
// reference model, plus a short check of the default-parameter build.
module tb_ultrasonic_trig_seq;

   localparam int PT  = 3;
   localparam int PER = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, mode, start;
   logic [3:0] mask;
   logic [3:0] trig;
   logic [1:0] ch_idx;
   logic       slot_start, busy, sweep_done;

   ultrasonic_trig_seq #(
      .NUM_CH(4), .PULSE_TICKS(PT), .PERIOD_TICKS(PER), .CNT_W(20)
   ) dut (
      .clk_1m(clk), .rst(rst), .en(en), .mode(mode), .start(start),
      .ch_mask(mask), .trig(trig), .ch_idx(ch_idx), .slot_start(slot_start),
      .busy(busy), .sweep_done(sweep_done)
   );

   logic       d_rst, d_en;
   logic [3:0] d_mask;
   logic [3:0] d_trig;
   logic [1:0] d_ch_idx;
   logic       d_slot_start, d_busy, d_sweep_done;

   ultrasonic_trig_seq dut_dflt (
      .clk_1m(clk), .rst(d_rst), .en(d_en), .mode(1'b0), .start(1'b0),
      .ch_mask(d_mask), .trig(d_trig), .ch_idx(d_ch_idx), .slot_start(d_slot_start),
      .busy(d_busy), .sweep_done(d_sweep_done)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: is a slot active, which channel owns it, cycles since its rise.
   bit         m_act = 1'b0;
   int         m_ch  = 0;
   int         m_t   = 0;
   logic [3:0] e_trig;
   bit         e_slot, e_busy, e_done;

   int rise_cyc[$];
   int rise_val[$];
   int done_cyc[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   function automatic int lowest_above(input logic [3:0] m, input int cur);
      for (int i = 0; i < 4; i++)
         if (m[i] && i > cur) return i;
      return -1;
   endfunction

   task automatic model_edge();
      int nx;
      bit wrapped;
      e_done = 1'b0;
      if (rst) begin
         m_act = 1'b0;
         m_ch  = 0;
      end else if (m_act) begin
         if (!en) begin
            m_act = 1'b0;
         end else if (m_t == PER - 1) begin
            nx      = lowest_above(mask, m_ch);
            wrapped = (nx < 0);
            if (wrapped) nx = lowest_above(mask, -1);
            if (nx < 0) begin
               m_act = 1'b0;
            end else if (mode && wrapped) begin
               m_act  = 1'b0;
               e_done = 1'b1;
            end else begin
               m_ch = nx;
               m_t  = 0;
            end
         end else begin
            m_t++;
         end
      end else if (en && mask != 4'b0 && (!mode || start)) begin
         m_ch  = lowest_above(mask, -1);
         m_t   = 0;
         m_act = 1'b1;
      end
      e_busy = m_act;
      e_slot = m_act && (m_t == 0);
      e_trig = (m_act && m_t < PT) ? 4'(1 << m_ch) : 4'b0;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_eq("trig", 32'(trig), 32'(e_trig));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("slot_start", 32'(slot_start), 32'(e_slot));
      check_eq("sweep_done", 32'(sweep_done), 32'(e_done));
      check_eq("ch_idx", 32'(ch_idx), 32'(m_ch));
      if (slot_start) begin
         rise_cyc.push_back(cyc);
         rise_val.push_back(int'(trig));
      end
      if (sweep_done) done_cyc.push_back(cyc);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      run(n);
      rst = 1'b0;
      rise_cyc.delete();
      rise_val.delete();
      done_cyc.delete();
   endtask

   initial begin
      int hi_cnt;
      int bad;
      int waited;
      rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; mask = 4'b0;
      d_rst = 1'b1; d_en = 1'b0; d_mask = 4'b0;
      @(negedge clk);

      // Reset, then enabled with an empty mask: nothing should launch.
      do_reset(5);
      en = 1'b1;
      run(25);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_rises", 32'(rise_cyc.size()), 32'd0);

      // Continuous round-robin over 1011.
      mask = 4'b1011;
      run(45);
      check_eq("rr_count", 32'(rise_cyc.size()), 32'd5);
      check_eq("rr_ch0", 32'(rise_val[0]), 32'h1);
      check_eq("rr_ch1", 32'(rise_val[1]), 32'h2);
      check_eq("rr_ch3", 32'(rise_val[2]), 32'h8);
      check_eq("rr_wrap", 32'(rise_val[3]), 32'h1);
      check_eq("rr_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(PER));

      // Single-shot sweep over 0110 with a stray second start.
      do_reset(2);
      en = 1'b1; mode = 1'b1; mask = 4'b0110;
      run(2);
      start = 1'b1; cycle(); start = 1'b0;
      run(4);
      start = 1'b1; cycle(); start = 1'b0;
      run(30);
      check_eq("ss_count", 32'(rise_cyc.size()), 32'd2);
      check_eq("ss_first", 32'(rise_val[0]), 32'h2);
      check_eq("ss_second", 32'(rise_val[1]), 32'h4);
      check_eq("ss_done_count", 32'(done_cyc.size()), 32'd1);
      check_eq("ss_done_time", 32'(done_cyc[0] - rise_cyc[0]), 32'd20);
      check_eq("ss_busy_end", 32'(busy), 32'd0);

      // Mask shrinks mid-slot, then empties mid-slot.
      do_reset(2);
      mode = 1'b0; mask = 4'b1111;
      cycle();
      run(4);
      mask = 4'b0001;
      run(12);
      mask = 4'b0000;
      run(6);
      check_eq("mm_count", 32'(rise_cyc.size()), 32'd2);
      check_eq("mm_first", 32'(rise_val[0]), 32'h1);
      check_eq("mm_repeat", 32'(rise_val[1]), 32'h1);
      check_eq("mm_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(PER));
      check_eq("mm_idle", 32'(busy), 32'd0);

      // Abort on the second pulse cycle, then relaunch.
      do_reset(2);
      mask = 4'b0110;
      run(2);
      en = 1'b0;
      cycle();
      check_eq("ab_trig", 32'(trig), 32'd0);
      check_eq("ab_busy", 32'(busy), 32'd0);
      check_eq("ab_idx_kept", 32'(ch_idx), 32'd1);
      en = 1'b1;
      rise_val.delete();
      cycle();
      check_eq("ab_relaunch", 32'(rise_val[0]), 32'h2);
      check_eq("ab_no_done", 32'(done_cyc.size()), 32'd0);

      // Reset during WAIT.
      mask = 4'b1111;
      run(6);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("rw_trig", 32'(trig), 32'd0);
      check_eq("rw_busy", 32'(busy), 32'd0);
      check_eq("rw_idx", 32'(ch_idx), 32'd0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         if (en && $urandom_range(0, 49) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
         if ($urandom_range(0, 79) == 0) mode = ~mode;
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) mask = 4'($urandom_range(0, 15));
         cycle();
      end
      rst = 1'b0;

      // Default-parameter build: 10-cycle pulse, then a long silent WAIT.
      @(negedge clk);
      d_rst = 1'b0; d_en = 1'b1; d_mask = 4'b0001;
      waited = 0;
      while (d_trig == 4'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq("dflt_rise", 32'(d_trig), 32'h1);
      check_eq("dflt_slot_start", 32'(d_slot_start), 32'd1);
      hi_cnt = 0;
      while (d_trig != 4'b0 && hi_cnt < 40) begin
         @(negedge clk);
         hi_cnt++;
      end
      check_eq("dflt_pulse_len", 32'(hi_cnt), 32'd10);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (d_trig != 4'b0 || !d_busy || d_slot_start) bad++;
      end
      check_eq("dflt_wait_quiet", 32'(bad), 32'd0);
      check_eq("dflt_idx", 32'(d_ch_idx), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
